uart_recv_cfg: RTL and testbench
================================

# uart_recv_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver. It is generalised in bit period, data width and stop-bit count, and adds false-start rejection, framing-error reporting and optional parity checking. It sits directly behind the board `rx` pin. It delivers each received word with a single-cycle `recv` strobe to the consuming logic in the `clk` domain.

## Interface
- `CLKS_PER_BIT`, default 10416: `clk` cycles per bit (100 MHz / 9600 baud). Legal range is 4 or more.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5 to 9.
- `STOP_BITS`, default 1: stop bits expected, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only meaningful with `UART_RECV_PARITY_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rx` in 1: asynchronous serial line. Idles high. LSB is sent first.
- `data` out `DATA_BITS`: last received word. Held until the next frame completes.
- `recv` out 1: one-cycle strobe. Means `data` holds a new valid word.
- `frame_err` out 1: one-cycle strobe. A stop bit was sampled low.
- `parity_err` out 1: one-cycle strobe when parity is compiled in; tied 0 otherwise.
- `busy` out 1: high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP, plus WAIT_HIGH.
  - IDLE → START when the synchronised `rx` is 0. The bit counter loads `CLKS_PER_BIT/2 - 1`. `busy` is set.
  - START, at mid-bit:
    - If `rx` is 0, go to DATA with bit index 0.
    - If `rx` is 1 (false start), return to IDLE. `busy` clears and no strobe is raised.
  - DATA samples every `CLKS_PER_BIT` cycles into a shift register, LSB first.
    - After `DATA_BITS` samples, go to PARITY if compiled in, otherwise STOP.
  - PARITY samples one bit. The error flag is set when the XOR of data and parity is wrong for the `PARITY_ODD` setting.
  - STOP samples `STOP_BITS` stop bits at mid-bit.
    - If all stop bits are 1 and there is no parity error: `data` is loaded, `recv` pulses, and the FSM goes to IDLE.
    - If any stop bit is 0: `frame_err` pulses, `data` is not updated, and the FSM goes to WAIT_HIGH.
    - If the stop bits are good but parity failed: `parity_err` pulses, `data` is not updated, and the FSM goes to IDLE.
  - WAIT_HIGH (line break) → IDLE once the synchronised `rx` is 1.
- Return to IDLE happens at mid-stop-bit, so a following start edge half a bit later is caught. This supports back-to-back frames.
- Counter width is `$clog2(CLKS_PER_BIT)`. The counter counts down to 0 and reloads with `CLKS_PER_BIT - 1`.
- `frame_err` and `parity_err` are never asserted together. `frame_err` takes precedence.

## Timing
- Reset values: `data`=0, `recv`=0, `frame_err`=0, `parity_err`=0, `busy`=0. FSM state is IDLE and the synchroniser flops are 1.
- Start is detected 2 cycles after the `rx` falling edge, because of the synchroniser.
- All outputs are registered. A strobe is asserted the cycle after the final mid-stop sample.
- Latency from the `rx` falling edge to the `recv` rising edge is `3 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT`, where P is 1 with parity and 0 without.
- `rst_n` asserted mid-frame aborts the frame immediately. All outputs go to their reset values and no strobe is raised. After release, the FSM needs a fresh falling edge to start a new frame.
- There is no ready/backpressure. Each new `recv` overwrites `data`.

## Configuration
- `UART_RECV_PARITY_EN` defined: the PARITY state exists and `parity_err` is functional.
- `UART_RECV_PARITY_EN` undefined: the PARITY state is removed, frames are N-type, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_e` enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the default-baud localparams and the parity-calc function.
- Sub-module `uart_rx_sync` is the 2-flop synchroniser with reset-to-1.
- The FSM, counters and shift register live in the top module.

## Test plan
Benches use `CLKS_PER_BIT`=16 for simulation speed.
1. Frame 0x55 (8N1) with a good stop bit → exactly one `recv` pulse, `data`=0x55, and `recv` rises 3+8+9·16=155 cycles after the start edge.
2. `rx` low for 5 cycles, then high → no `recv` and no `frame_err`. `busy` returns to 0 within 12 cycles.
3. Frame 0xA3 with stop bit 0, line held low for 40 cycles → one `frame_err` pulse, no `recv`, and `data` keeps its previous value. The next frame is received only after `rx` returns high.
4. With `UART_RECV_PARITY_EN`, even parity, send 0x07 with parity bit 0 (correct bit is 1) → `parity_err` pulse, no `recv`. Resend with parity bit 1 → `recv`, `data`=0x07.
5. Back-to-back frames 0x00 then 0xFF with no idle gap → two `recv` pulses 160 cycles apart, with `data` 0x00 then 0xFF.
6. Assert `rst_n` low during data bit 4 of frame 0x3C, then release and send 0x81 → no strobe for the aborted frame, all outputs 0 during reset, then `recv` with `data`=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_rx_state_e;

  // Default line rate: 100 MHz core clock at 9600 baud.
  localparam int UART_DEF_CLK_HZ       = 100_000_000;
  localparam int UART_DEF_BAUD         = 9600;
  localparam int UART_DEF_CLKS_PER_BIT = UART_DEF_CLK_HZ / UART_DEF_BAUD;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int UART_MAX_DATA_BITS = 9;

  // True when the received parity bit disagrees with the data word.
  // odd = 0 expects even total parity, odd = 1 expects odd total parity.
  function automatic logic uart_parity_bad(input logic [UART_MAX_DATA_BITS-1:0] d,
                                           input logic par,
                                           input logic odd);
    return ((^d) ^ par) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; both flops reset high (idle line).
// Latency: 2 clk cycles from pin to synchronised output.
// Backpressure: none, free-running.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_sync_o
);

  logic s1_q;
  logic s2_q;

  // Resample the pin twice; reset to the idle level so reset release is not a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
    end
  end

  assign rx_sync_o = s2_q;

endmodule

// File: rtl/uart_recv_cfg.sv
// Configurable UART receiver (bit period, width, stop bits; parity when UART_RECV_PARITY_EN is defined).
// Latency: rx fall to recv = 3 + CLKS_PER_BIT/2 + (DATA_BITS + parity + STOP_BITS) * CLKS_PER_BIT cycles.
// Backpressure: none; each recv strobe overwrites data.
module uart_recv_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 recv,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx),
    .rx_sync_o (rx_s)
  );

  uart_rx_state_e       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic                 stop_bad_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 recv_q;
  logic                 ferr_q;
  logic                 busy_q;
`ifdef UART_RECV_PARITY_EN
  logic                 par_bad_q;
  logic                 perr_q;
`endif

  // Frame FSM: mid-bit sampling, shift register, and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      stop_bad_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      recv_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      recv_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s) begin
            state_q   <= DATA;
            cnt_q     <= FULL_LOAD;
            bit_idx_q <= '0;
          end else begin
            // Line went back high before mid-start: glitch, not a frame.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q   <= FULL_LOAD;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_IDX) begin
              stop_idx_q <= 1'b0;
              stop_bad_q <= 1'b0;
`ifdef UART_RECV_PARITY_EN
              state_q    <= PARITY;
`else
              state_q    <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end

`ifdef UART_RECV_PARITY_EN
        PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q     <= FULL_LOAD;
            par_bad_q <= uart_parity_bad(UART_MAX_DATA_BITS'(shift_q), rx_s, PARITY_ODD);
            state_q   <= STOP;
          end
        end
`endif

        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (stop_idx_q != STOP_LAST) begin
            // Earlier stop bit: remember a low sample, decide at the last one.
            stop_bad_q <= stop_bad_q | ~rx_s;
            stop_idx_q <= stop_idx_q + 1'b1;
            cnt_q      <= FULL_LOAD;
          end else if (!rx_s || stop_bad_q) begin
            // Framing error wins over parity; wait for the break to end.
            ferr_q  <= 1'b1;
            state_q <= WAIT_HIGH;
          end
`ifdef UART_RECV_PARITY_EN
          else if (par_bad_q) begin
            perr_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`endif
          else begin
            // Leave at mid-stop so a start edge half a bit later is caught.
            data_q  <= shift_q;
            recv_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign recv      = recv_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

`ifdef UART_RECV_PARITY_EN
  assign parity_err = perr_q;
`else
  // No parity hardware: the sense bit is irrelevant and the strobe is constant low.
  assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_recv_cfg.sv
`timescale 1ns/1ps
module tb_uart_recv_cfg;

  localparam int CPB = 16;
`ifdef UART_RECV_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT   = 3 + CPB / 2 + (8 + P + 1) * CPB;
  localparam int FRAME = (1 + 8 + P + 1) * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       recv;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         recv_cnt;
  int         ferr_cnt;
  int         perr_cnt;
  int         perr_total = 0;
  int         ferr_cyc;
  int         recv_cyc[$];
  logic [7:0] recv_dat[$];

  uart_recv_cfg #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .recv       (recv),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (recv) begin
      recv_cnt++;
      recv_cyc.push_back(cyc);
      recv_dat.push_back(data);
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (parity_err) begin
      perr_cnt++;
      perr_total++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    recv_cnt = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    ferr_cyc = -1;
    recv_cyc.delete();
    recv_dat.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // flip_par = 1 sends the wrong (non-even) parity bit when parity is built in.
  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RECV_PARITY_EN
    drive_bit((^d) ^ flip_par);
`else
    if (flip_par) rx = 1'b1;
`endif
    drive_bit(stop_v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %0h want 0", data); end
    n_cmp++; if (recv !== 1'b0) begin n_bad++; $display("FAIL reset_recv got %0b want 0", recv); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %0b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %0b want 0", parity_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic_frame();
    int start;
    int lat;
    clear_mon();
    start = cyc;
    send_frame(8'h55, 1'b0, 1'b1);
    tick(4);
    lat = (recv_cyc.size() > 0) ? recv_cyc[0] - start : -1;
    n_cmp++; if (recv_cnt !== 1) begin n_bad++; $display("FAIL basic_recv_count got %0d want 1", recv_cnt); end
    n_cmp++; if (data !== 8'h55) begin n_bad++; $display("FAIL basic_data got %0h want 55", data); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL basic_ferr got %0d want 0", ferr_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle got %0b want 0", busy); end
  endtask

  task automatic test_false_start();
    logic saw_busy;
    clear_mon();
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); saw_busy |= busy; end
    rx = 1'b1;
    for (int i = 0; i < 7; i++) begin tick(1); saw_busy |= busy; end
    n_cmp++; if (saw_busy !== 1'b1) begin n_bad++; $display("FAIL false_start_busy_seen got %0b want 1", saw_busy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL false_start_busy_12 got %0b want 0", busy); end
    tick(3 * CPB);
    n_cmp++; if (recv_cnt !== 0) begin n_bad++; $display("FAIL false_start_recv got %0d want 0", recv_cnt); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL false_start_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_frame_err();
    int start;
    clear_mon();
    start = cyc;
    send_frame(8'hA3, 1'b0, 1'b0);
    tick(40 - CPB);
    n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
    n_cmp++; if (ferr_cyc - start !== LAT) begin n_bad++; $display("FAIL ferr_latency got %0d want %0d", ferr_cyc - start, LAT); end
    n_cmp++; if (recv_cnt !== 0) begin n_bad++; $display("FAIL ferr_no_recv got %0d want 0", recv_cnt); end
    n_cmp++; if (data !== 8'h55) begin n_bad++; $display("FAIL ferr_data_held got %0h want 55", data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_wait_high_busy got %0b want 1", busy); end
    rx = 1'b1;
    tick(8);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_release_busy got %0b want 0", busy); end
    clear_mon();
    send_frame(8'h3A, 1'b0, 1'b1);
    tick(4);
    n_cmp++; if (recv_cnt !== 1) begin n_bad++; $display("FAIL ferr_next_recv got %0d want 1", recv_cnt); end
    n_cmp++; if (data !== 8'h3A) begin n_bad++; $display("FAIL ferr_next_data got %0h want 3a", data); end
  endtask

  task automatic test_parity();
`ifdef UART_RECV_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(4);
    n_cmp++; if (perr_cnt !== 1) begin n_bad++; $display("FAIL par_err_count got %0d want 1", perr_cnt); end
    n_cmp++; if (recv_cnt !== 0) begin n_bad++; $display("FAIL par_err_no_recv got %0d want 0", recv_cnt); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL par_err_no_ferr got %0d want 0", ferr_cnt); end
    n_cmp++; if (data !== 8'h3A) begin n_bad++; $display("FAIL par_err_data_held got %0h want 3a", data); end
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b1);
    tick(4);
    n_cmp++; if (recv_cnt !== 1) begin n_bad++; $display("FAIL par_ok_recv got %0d want 1", recv_cnt); end
    n_cmp++; if (data !== 8'h07) begin n_bad++; $display("FAIL par_ok_data got %0h want 07", data); end
    n_cmp++; if (perr_cnt !== 0) begin n_bad++; $display("FAIL par_ok_perr got %0d want 0", perr_cnt); end
`else
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b1);
    tick(4);
    n_cmp++; if (recv_cnt !== 1) begin n_bad++; $display("FAIL nopar_recv got %0d want 1", recv_cnt); end
    n_cmp++; if (data !== 8'h07) begin n_bad++; $display("FAIL nopar_data got %0h want 07", data); end
    n_cmp++; if (perr_total !== 0) begin n_bad++; $display("FAIL nopar_perr_total got %0d want 0", perr_total); end
`endif
  endtask

  task automatic test_back_to_back();
    int start;
    int gap;
    int lat;
    clear_mon();
    start = cyc;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    tick(4);
    n_cmp++; if (recv_cnt !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", recv_cnt); end
    if (recv_cyc.size() == 2) begin
      gap = recv_cyc[1] - recv_cyc[0];
      lat = recv_cyc[0] - start;
      n_cmp++; if (recv_dat[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_data0 got %0h want 00", recv_dat[0]); end
      n_cmp++; if (recv_dat[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_data1 got %0h want ff", recv_dat[1]); end
      n_cmp++; if (gap !== FRAME) begin n_bad++; $display("FAIL b2b_gap got %0d want %0d", gap, FRAME); end
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    clear_mon();
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    tick(CPB / 2);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %0b want 1", busy); end
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL abort_rst_data got %0h want 0", data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_rst_busy got %0b want 0", busy); end
    n_cmp++; if ({recv, frame_err, parity_err} !== 3'b000) begin
      n_bad++; $display("FAIL abort_rst_strobes got %0b want 000", {recv, frame_err, parity_err});
    end
    tick(4);
    rst_n = 1'b1;
    tick(FRAME + CPB);
    n_cmp++; if (recv_cnt + ferr_cnt + perr_cnt !== 0) begin
      n_bad++; $display("FAIL abort_no_strobe got %0d want 0", recv_cnt + ferr_cnt + perr_cnt);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after got %0b want 0", busy); end
    clear_mon();
    send_frame(8'h81, 1'b0, 1'b1);
    tick(4);
    n_cmp++; if (recv_cnt !== 1) begin n_bad++; $display("FAIL abort_next_recv got %0d want 1", recv_cnt); end
    n_cmp++; if (data !== 8'h81) begin n_bad++; $display("FAIL abort_next_data got %0h want 81", data); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    clear_mon();
    test_reset();
    test_basic_frame();
    test_false_start();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
